// File: rtl/tx_serializer_10b.sv
// 10-bit codeword serializer placed after the 8b/10b encoder: shifts each word LSB
// first onto tx_out and paces the encoder with a registered nextword_enable strobe.
module tx_serializer_10b #(
    parameter int   CLKS_PER_BIT = 4,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] word_in,
    output logic       nextword_enable,
    output logic       tx_out,
    output logic       running,
    output logic       word_strobe
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, PRIME, LOAD, RUN} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [9:0]       shreg_reg, shreg_next;
    logic             tx_reg, tx_next;
    logic             nwe_reg, nwe_next;
    logic             strobe_reg, strobe_next;
    logic             running_reg, running_next;
    logic             bit_end, word_end, word_end_ahead;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            tx_reg      <= IDLE_LEVEL;
            nwe_reg     <= 1'b0;
            strobe_reg  <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            tx_reg      <= tx_next;
            nwe_reg     <= nwe_next;
            strobe_reg  <= strobe_next;
            running_reg <= running_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        bit_end      = (clk_cnt_reg == CNT_MAX);
        word_end     = bit_end && (bit_cnt_reg == 4'd9);

        case (state_reg)
            IDLE: begin
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                if (en) begin
                    state_next = PRIME;
                end
            end
            PRIME: begin
                state_next = LOAD;
            end
            LOAD: begin
                shreg_next   = word_in;
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                state_next   = RUN;
            end
            RUN: begin
                if (!bit_end) begin
                    clk_cnt_next = clk_cnt_reg + CNT_W'(1);
                end else begin
                    clk_cnt_next = '0;
                    if (!word_end) begin
                        shreg_next   = {1'b0, shreg_reg[9:1]};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else begin
                        bit_cnt_next = '0;
                        // strobe_reg already holds the continue/stop decision for this word_end
                        if (strobe_reg) begin
                            shreg_next = word_in;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes are registered, so the reload decision is taken one cycle early:
    // en is sampled in the cycle that precedes word_end.
    always_comb begin
        word_end_ahead = (state_next == RUN) && (clk_cnt_next == CNT_MAX) &&
                         (bit_cnt_next == 4'd9);
        strobe_next    = (state_next == LOAD) || (word_end_ahead && en);
        nwe_next       = (state_next == PRIME) || strobe_next;
        running_next   = (state_next != IDLE);
        tx_next        = (state_next == RUN) ? shreg_next[0] : IDLE_LEVEL;
    end

    assign nextword_enable = nwe_reg;
    assign word_strobe     = strobe_reg;
    assign running         = running_reg;
    assign tx_out          = tx_reg;
endmodule

// File: tb/tb_tx_serializer_10b.sv
// Directed bench for tx_serializer_10b: three instances cover CLKS_PER_BIT=4,
// CLKS_PER_BIT=1 and IDLE_LEVEL=1; each has a counting encoder model on word_in.
`timescale 1ns/1ps
module tb_tx_serializer_10b;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // instance a: CLKS_PER_BIT=4, IDLE_LEVEL=0
    logic       rst_a = 1'b1, en_a = 1'b0, hold_a = 1'b1;
    logic [9:0] word_a, cnt_a;
    logic       nwe_a, tx_a, run_a, strobe_a;
    // instance b: CLKS_PER_BIT=1
    logic       rst_b = 1'b1, en_b = 1'b0;
    logic [9:0] cnt_b;
    logic       nwe_b, tx_b, run_b, strobe_b;
    // instance c: IDLE_LEVEL=1
    logic       rst_c = 1'b1, en_c = 1'b0;
    logic       nwe_c, tx_c, run_c, strobe_c;

    // encoder models: word 0x001 is the stale word present before the first strobe
    always @(posedge clk) begin
        if (rst_a) cnt_a <= 10'd1;
        else if (nwe_a) cnt_a <= cnt_a + 10'd1;
        if (rst_b) cnt_b <= 10'd1;
        else if (nwe_b) cnt_b <= cnt_b + 10'd1;
    end
    assign word_a = hold_a ? 10'b0101111100 : cnt_a;

    tx_serializer_10b #(.CLKS_PER_BIT(4), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .word_in(word_a),
        .nextword_enable(nwe_a), .tx_out(tx_a), .running(run_a), .word_strobe(strobe_a));
    tx_serializer_10b #(.CLKS_PER_BIT(1), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .word_in(cnt_b),
        .nextword_enable(nwe_b), .tx_out(tx_b), .running(run_b), .word_strobe(strobe_b));
    tx_serializer_10b #(.CLKS_PER_BIT(4), .IDLE_LEVEL(1'b1)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .word_in(10'h3a5),
        .nextword_enable(nwe_c), .tx_out(tx_c), .running(run_c), .word_strobe(strobe_c));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b1; hold_a = 1'b1;
        repeat (3) tick();
        n_cmp++; if (tx_a !== 1'b0) begin n_bad++; $display("FAIL reset_tx got=%b exp=0", tx_a); end
        n_cmp++; if (nwe_a !== 1'b0) begin n_bad++; $display("FAIL reset_nwe got=%b exp=0", nwe_a); end
        n_cmp++; if (run_a !== 1'b0) begin n_bad++; $display("FAIL reset_running got=%b exp=0", run_a); end
        n_cmp++; if (strobe_a !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got=%b exp=0", strobe_a); end
        $display("test_reset done");
    endtask

    task automatic test_k285();
        logic [9:0] k;
        logic e_tx, e_nwe, e_stb;
        k = 10'b0101111100;
        en_a = 1'b0;
        rst_a = 1'b0; en_a = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            e_tx  = (c >= 3) ? k[((c - 3) / 4) % 10] : 1'b0;
            e_stb = (c == 2) || (c == 42);
            e_nwe = (c == 1) || e_stb;
            n_cmp++; if (tx_a !== e_tx) begin n_bad++; $display("FAIL k285_tx c=%0d got=%b exp=%b", c, tx_a, e_tx); end
            n_cmp++; if (nwe_a !== e_nwe) begin n_bad++; $display("FAIL k285_nwe c=%0d got=%b exp=%b", c, nwe_a, e_nwe); end
            n_cmp++; if (strobe_a !== e_stb) begin n_bad++; $display("FAIL k285_strobe c=%0d got=%b exp=%b", c, strobe_a, e_stb); end
        end
        $display("test_k285 done");
    endtask

    // Words 0x002.. back to back, cycles 1..122 relative to en rising.
    task automatic test_word_order();
        logic [9:0] w;
        logic e_tx, e_nwe, e_stb;
        rst_a = 1'b1; en_a = 1'b0; hold_a = 1'b0;
        repeat (2) tick();
        rst_a = 1'b0; en_a = 1'b1;
        for (int c = 1; c <= 122; c++) begin
            tick();
            w     = 10'((c - 3) / 40 + 2);
            e_tx  = (c >= 3) ? w[((c - 3) % 40) / 4] : 1'b0;
            e_stb = (c == 2) || (c >= 42 && (c - 2) % 40 == 0);
            e_nwe = (c == 1) || e_stb;
            n_cmp++; if (tx_a !== e_tx) begin n_bad++; $display("FAIL order_tx c=%0d got=%b exp=%b", c, tx_a, e_tx); end
            n_cmp++; if (nwe_a !== e_nwe) begin n_bad++; $display("FAIL order_nwe c=%0d got=%b exp=%b", c, nwe_a, e_nwe); end
            n_cmp++; if (strobe_a !== e_stb) begin n_bad++; $display("FAIL order_strobe c=%0d got=%b exp=%b", c, strobe_a, e_stb); end
            n_cmp++; if (run_a !== 1'b1) begin n_bad++; $display("FAIL order_running c=%0d got=%b exp=1", c, run_a); end
            if (c >= 42 && (c - 2) % 40 == 0) $display("word %0d on line: 0x%03h", (c - 42) / 40, w);
        end
    endtask

    // Word 0x005 (cycles 123..162) loses en at bit 3; restart loads 0x007 at 166.
    task automatic test_en_drop();
        logic [9:0] w5, w7;
        logic e_tx, e_nwe, e_stb, e_run;
        w5 = 10'h005; w7 = 10'h007;
        for (int c = 123; c <= 190; c++) begin
            tick();
            e_nwe = 1'b0; e_stb = 1'b0; e_run = 1'b1; e_tx = 1'b0;
            if (c <= 162) e_tx = w5[(c - 123) / 4];
            else if (c <= 164) e_run = 1'b0;
            else if (c == 165) e_nwe = 1'b1;
            else if (c == 166) begin e_nwe = 1'b1; e_stb = 1'b1; end
            else e_tx = w7[(c - 167) / 4];
            n_cmp++; if (tx_a !== e_tx) begin n_bad++; $display("FAIL drop_tx c=%0d got=%b exp=%b", c, tx_a, e_tx); end
            n_cmp++; if (nwe_a !== e_nwe) begin n_bad++; $display("FAIL drop_nwe c=%0d got=%b exp=%b", c, nwe_a, e_nwe); end
            n_cmp++; if (strobe_a !== e_stb) begin n_bad++; $display("FAIL drop_strobe c=%0d got=%b exp=%b", c, strobe_a, e_stb); end
            n_cmp++; if (run_a !== e_run) begin n_bad++; $display("FAIL drop_running c=%0d got=%b exp=%b", c, run_a, e_run); end
            if (c == 136) en_a = 1'b0;
            if (c == 164) en_a = 1'b1;
        end
        $display("test_en_drop done");
    endtask

    // rst pulse during bit 6 of word 0x007; restart must load 0x002 after PRIME.
    task automatic test_rst_mid();
        logic [9:0] w7, w2;
        logic e_tx, e_nwe, e_stb, e_run;
        w7 = 10'h007; w2 = 10'h002;
        for (int c = 191; c <= 235; c++) begin
            tick();
            e_nwe = 1'b0; e_stb = 1'b0; e_run = 1'b1; e_tx = 1'b0;
            if (c <= 192) e_tx = w7[(c - 167) / 4];
            else if (c == 193) e_run = 1'b0;
            else if (c == 194) e_nwe = 1'b1;
            else if (c == 195) begin e_nwe = 1'b1; e_stb = 1'b1; end
            else begin
                e_tx = w2[(c - 196) / 4];
                e_stb = (c == 235); e_nwe = e_stb;
            end
            n_cmp++; if (tx_a !== e_tx) begin n_bad++; $display("FAIL rst_tx c=%0d got=%b exp=%b", c, tx_a, e_tx); end
            n_cmp++; if (nwe_a !== e_nwe) begin n_bad++; $display("FAIL rst_nwe c=%0d got=%b exp=%b", c, nwe_a, e_nwe); end
            n_cmp++; if (strobe_a !== e_stb) begin n_bad++; $display("FAIL rst_strobe c=%0d got=%b exp=%b", c, strobe_a, e_stb); end
            n_cmp++; if (run_a !== e_run) begin n_bad++; $display("FAIL rst_running c=%0d got=%b exp=%b", c, run_a, e_run); end
            if (c == 192) rst_a = 1'b1;
            if (c == 193) rst_a = 1'b0;
        end
        $display("test_rst_mid done");
    endtask

    task automatic test_cpb1();
        logic [9:0] w;
        logic e_tx, e_nwe, e_stb;
        int pulses;
        pulses = 0;
        rst_b = 1'b1; en_b = 1'b0;
        repeat (3) tick();
        rst_b = 1'b0; en_b = 1'b1;
        for (int e = 1; e <= 1002; e++) begin
            tick();
            w     = 10'((e - 3) / 10 + 2);
            e_tx  = (e >= 3) ? w[(e - 3) % 10] : 1'b0;
            e_stb = (e >= 2) && ((e - 2) % 10 == 0);
            e_nwe = (e == 1) || e_stb;
            if (nwe_b === 1'b1) pulses++;
            n_cmp++; if (tx_b !== e_tx) begin n_bad++; $display("FAIL cpb1_tx e=%0d got=%b exp=%b", e, tx_b, e_tx); end
            n_cmp++; if (nwe_b !== e_nwe) begin n_bad++; $display("FAIL cpb1_nwe e=%0d got=%b exp=%b", e, nwe_b, e_nwe); end
            n_cmp++; if (strobe_b !== e_stb) begin n_bad++; $display("FAIL cpb1_strobe e=%0d got=%b exp=%b", e, strobe_b, e_stb); end
        end
        n_cmp++; if (pulses != 102) begin n_bad++; $display("FAIL cpb1_pulse_count got=%0d exp=102", pulses); end
        $display("test_cpb1 done: %0d nextword pulses", pulses);
    endtask

    task automatic test_idle_level();
        rst_c = 1'b1; en_c = 1'b0;
        repeat (3) tick();
        n_cmp++; if (tx_c !== 1'b1) begin n_bad++; $display("FAIL idle_reset_tx got=%b exp=1", tx_c); end
        rst_c = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            n_cmp++; if (tx_c !== 1'b1) begin n_bad++; $display("FAIL idle_tx c=%0d got=%b exp=1", c, tx_c); end
            n_cmp++; if (nwe_c !== 1'b0) begin n_bad++; $display("FAIL idle_nwe c=%0d got=%b exp=0", c, nwe_c); end
            n_cmp++; if (strobe_c !== 1'b0) begin n_bad++; $display("FAIL idle_strobe c=%0d got=%b exp=0", c, strobe_c); end
            n_cmp++; if (run_c !== 1'b0) begin n_bad++; $display("FAIL idle_running c=%0d got=%b exp=0", c, run_c); end
        end
        $display("test_idle_level done");
    endtask

    initial begin
        test_reset();
        test_k285();
        test_word_order();
        test_en_drop();
        test_rst_mid();
        test_cpb1();
        test_idle_level();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
